// File: rtl/rvc_mem_dump_sc.sv
// End-of-test D_MEM reader: walks D_MEM word by word and streams (addr, data) out.
// Optional running checksum output enabled by defining RVC_DUMP_CSUM_EN.
module rvc_mem_dump_sc #(
    parameter logic [31:0] D_MEM_OFFSET  = 32'h1000,
    parameter int          MSB_D_MEM     = 11,
    parameter logic [31:0] EBREAK_OPCODE = 32'h00100073
) (
    input  logic        Clock,
    input  logic        Rst,
    input  logic [31:0] Instruction,
    input  logic        Start,
    output logic        MemRdEn,
    output logic [31:0] MemRdAddr,
    input  logic [31:0] MemRdData,
    output logic        DumpValid,
    input  logic        DumpReady,
    output logic [31:0] DumpAddr,
    output logic [31:0] DumpData,
    output logic        Busy,
    output logic        Done
`ifdef RVC_DUMP_CSUM_EN
   ,output logic [31:0] DumpCsum
`endif
);

    localparam int CW    = MSB_D_MEM - 1;
    localparam int WORDS = 2 ** CW;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        WAIT,
        SEND
    } state_t;

    state_t        state;
    logic [CW-1:0] count;
    logic          ebreak_prev;
    logic          ebreak_hit;
    logic          trigger;
    logic          last;
    logic [31:0]   next_addr;

    // A held EBREAK only fires on its first cycle
    assign ebreak_hit = (Instruction == EBREAK_OPCODE);
    assign trigger    = Start | (ebreak_hit & ~ebreak_prev);
    assign last       = (count == CW'(WORDS - 1));
    assign next_addr  = D_MEM_OFFSET + ((32'(count) + 32'd1) << 2);

    always_ff @(posedge Clock or negedge Rst) begin
        if (!Rst) begin
            state       <= IDLE;
            count       <= '0;
            ebreak_prev <= 1'b0;
            MemRdEn     <= 1'b0;
            MemRdAddr   <= '0;
            DumpValid   <= 1'b0;
            DumpAddr    <= '0;
            DumpData    <= '0;
            Busy        <= 1'b0;
            Done        <= 1'b0;
`ifdef RVC_DUMP_CSUM_EN
            DumpCsum    <= '0;
`endif
        end else begin
            ebreak_prev <= ebreak_hit;
            case (state)
                IDLE: begin
                    if (trigger) begin
                        state     <= READ;
                        count     <= '0;
                        Done      <= 1'b0;
                        Busy      <= 1'b1;
                        MemRdEn   <= 1'b1;
                        MemRdAddr <= D_MEM_OFFSET;
`ifdef RVC_DUMP_CSUM_EN
                        DumpCsum  <= '0;
`endif
                    end
                end
                READ: begin
                    MemRdEn <= 1'b0;
                    state   <= WAIT;
                end
                WAIT: begin
                    DumpData  <= MemRdData;
                    DumpAddr  <= MemRdAddr;
                    DumpValid <= 1'b1;
                    state     <= SEND;
                end
                SEND: begin
                    if (DumpReady) begin
                        DumpValid <= 1'b0;
`ifdef RVC_DUMP_CSUM_EN
                        DumpCsum  <= DumpCsum + DumpData;
`endif
                        if (last) begin
                            state <= IDLE;
                            Busy  <= 1'b0;
                            Done  <= 1'b1;
                        end else begin
                            count     <= count + 1'b1;
                            MemRdEn   <= 1'b1;
                            MemRdAddr <= next_addr;
                            state     <= READ;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
